// File: rtl/timer_periph.sv
// Memory-mapped timer / SysTick peripheral on the MEM-stage data bus.
// Optional TL prescaler is enabled with `define TIMER_PRESCALE_EN.
module timer_periph #(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
   parameter int          PRESCALE  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRd,
   input  logic        MemWr,
   input  logic [31:0] Addr,
   input  logic [31:0] WrData,
   output logic [31:0] RdData,
   output logic        Hit,
   output logic        IRQ,
   output logic [31:0] SysTick
);

   localparam logic [31:0] ADDR_TH   = BASE_ADDR + 32'h0000_0000;
   localparam logic [31:0] ADDR_TL   = BASE_ADDR + 32'h0000_0004;
   localparam logic [31:0] ADDR_TCON = BASE_ADDR + 32'h0000_0008;
   localparam logic [31:0] ADDR_ST   = BASE_ADDR + 32'h0000_0014;

   if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
      $error("timer_periph: PRESCALE must be in 1..65535");
   end

   logic [31:0] th_r;
   logic [31:0] tl_r;
   logic [2:0]  tcon_r;
   logic [31:0] systick_r;

   logic        sel_th_s;
   logic        sel_tl_s;
   logic        sel_tcon_s;
   logic        sel_st_s;
   logic [31:0] rd_sel_s;
   logic        wr_th_s;
   logic        wr_tl_s;
   logic        wr_tcon_s;
   logic        tick_s;
   logic        ovf_s;
   logic        irq_set_s;

   // Exact-match address decode and zero-latency read mux
   always_comb begin
      sel_th_s   = 1'b0;
      sel_tl_s   = 1'b0;
      sel_tcon_s = 1'b0;
      sel_st_s   = 1'b0;
      rd_sel_s   = 32'h0000_0000;
      case (Addr)
         ADDR_TH: begin
            sel_th_s = 1'b1;
            rd_sel_s = th_r;
         end
         ADDR_TL: begin
            sel_tl_s = 1'b1;
            rd_sel_s = tl_r;
         end
         ADDR_TCON: begin
            sel_tcon_s = 1'b1;
            rd_sel_s   = {29'd0, tcon_r};
         end
         ADDR_ST: begin
            sel_st_s = 1'b1;
            rd_sel_s = systick_r;
         end
         default: begin
            rd_sel_s = 32'h0000_0000;
         end
      endcase
      Hit = sel_th_s | sel_tl_s | sel_tcon_s | sel_st_s;
      if (MemRd && Hit) begin
         RdData = rd_sel_s;
      end else begin
         RdData = 32'h0000_0000;
      end
   end

   // Write strobes, overflow detection and IRQ set qualification
   always_comb begin
      wr_th_s   = MemWr & sel_th_s;
      wr_tl_s   = MemWr & sel_tl_s;
      wr_tcon_s = MemWr & sel_tcon_s;
      ovf_s     = tcon_r[0] & tick_s & (tl_r == 32'hFFFF_FFFF);
      // A bus write to TL pre-empts the overflow, so it cannot raise the IRQ
      irq_set_s = ovf_s & tcon_r[1] & ~wr_tl_s;
   end

`ifdef TIMER_PRESCALE_EN
   localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

   logic [15:0] ps_r;

   // Prescale counter; restarts whenever the timer is disabled or TL is rewritten
   always_ff @(posedge clk) begin
      if (rst) begin
         ps_r <= 16'd0;
      end else if (!tcon_r[0] || wr_tl_s) begin
         ps_r <= 16'd0;
      end else if (ps_r == PS_LAST) begin
         ps_r <= 16'd0;
      end else begin
         ps_r <= ps_r + 16'd1;
      end
   end

   // TL advances only on the last prescale count
   always_comb begin
      tick_s = (ps_r == PS_LAST);
   end
`else
   // Without the prescaler TL may advance every cycle
   always_comb begin
      tick_s = 1'b1;
   end
`endif

   // Register file, timer counter and free-running SysTick
   always_ff @(posedge clk) begin
      if (rst) begin
         th_r      <= 32'h0000_0000;
         tl_r      <= 32'h0000_0000;
         tcon_r    <= 3'b000;
         systick_r <= 32'h0000_0000;
      end else begin
         systick_r <= systick_r + 32'd1;
         if (wr_th_s) begin
            th_r <= WrData;
         end
         // Reload uses the TH value from before any same-cycle TH write
         if (wr_tl_s) begin
            tl_r <= WrData;
         end else if (tcon_r[0] && tick_s) begin
            tl_r <= ovf_s ? th_r : tl_r + 32'd1;
         end
         if (wr_tcon_s) begin
            tcon_r[1:0] <= WrData[1:0];
         end
         // Hardware set beats software write-1-to-clear
         if (irq_set_s) begin
            tcon_r[2] <= 1'b1;
         end else if (wr_tcon_s && WrData[2]) begin
            tcon_r[2] <= 1'b0;
         end
      end
   end

   assign IRQ     = tcon_r[2];
   assign SysTick = systick_r;

endmodule

// File: tb/tb_timer_periph.sv
// Scoreboard bench for timer_periph: expected read data is queued at drive
// time and compared by a monitor at the falling edge.
module tb_timer_periph;

`ifdef TIMER_PRESCALE_EN
   localparam int PS = 4;
`else
   localparam int PS = 1;
`endif

   localparam logic [31:0] A_TH   = 32'h4000_0000;
   localparam logic [31:0] A_TL   = 32'h4000_0004;
   localparam logic [31:0] A_TCON = 32'h4000_0008;
   localparam logic [31:0] A_DIG  = 32'h4000_0010;
   localparam logic [31:0] A_ST   = 32'h4000_0014;

   logic        clk = 1'b0;
   logic        rst;
   logic        MemRd;
   logic        MemWr;
   logic [31:0] Addr;
   logic [31:0] WrData;
   logic [31:0] RdData;
   logic        Hit;
   logic        IRQ;
   logic [31:0] SysTick;

   typedef struct {
      string       tag;
      logic [31:0] rd;
      logic        hit;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] tb_cycles;
   logic [31:0] st0;
   logic [31:0] rv;

   timer_periph #(.BASE_ADDR(32'h4000_0000), .PRESCALE(PS)) dut (
      .clk(clk), .rst(rst), .MemRd(MemRd), .MemWr(MemWr), .Addr(Addr),
      .WrData(WrData), .RdData(RdData), .Hit(Hit), .IRQ(IRQ), .SysTick(SysTick)
   );

   always #5 clk = ~clk;

   // Reference cycle count since the last reset edge
   always @(posedge clk) begin
      if (rst) tb_cycles <= 32'd0;
      else     tb_cycles <= tb_cycles + 32'd1;
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Monitor: every read cycle pops one expectation
   always @(negedge clk) begin
      if (MemRd) begin
         if (sb_q.size() == 0) begin
            check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check_eq({e.tag, "_rd"}, RdData, e.rd);
            check_eq({e.tag, "_hit"}, {31'd0, Hit}, {31'd0, e.hit});
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      MemWr  = 1'b1;
      Addr   = a;
      WrData = d;
      cyc();
      MemWr  = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input logic hit,
                           input string tag, input int irq_exp);
      exp_t e;
      MemRd = 1'b1;
      Addr  = a;
      e.tag = tag;
      e.rd  = exp;
      e.hit = hit;
      sb_q.push_back(e);
      @(negedge clk);
      if (irq_exp >= 0) check_eq({tag, "_irq"}, {31'd0, IRQ}, 32'(irq_exp));
      cyc();
      MemRd = 1'b0;
   endtask

   initial begin
      rst = 1'b1; MemRd = 1'b0; MemWr = 1'b0; Addr = 32'd0; WrData = 32'd0;
      repeat (2) cyc();
      // Reset state, read while reset is still held
      bus_read(A_TH,   32'd0, 1'b1, "rst_th",   0);
      bus_read(A_TL,   32'd0, 1'b1, "rst_tl",   0);
      bus_read(A_TCON, 32'd0, 1'b1, "rst_tcon", 0);
      bus_read(A_ST,   32'd0, 1'b1, "rst_st",   0);
      rst = 1'b0;
      check_eq("systick_start", SysTick, tb_cycles);

      // Decode: unmapped, foreign and unaligned addresses
      bus_read(A_DIG,        32'd0, 1'b0, "dec_digit", -1);
      bus_read(32'h0000_0004, 32'd0, 1'b0, "dec_low",  -1);
      bus_read(32'h4000_0001, 32'd0, 1'b0, "dec_unal", -1);
      bus_write(A_DIG, 32'hFFFF_FFFF);
      bus_read(A_TH,   32'd0, 1'b1, "dig_th",   -1);
      bus_read(A_TL,   32'd0, 1'b1, "dig_tl",   -1);
      bus_read(A_TCON, 32'd0, 1'b1, "dig_tcon", 0);

      // SysTick ignores writes and counts every cycle
      bus_write(A_ST, 32'd5);
      bus_read(A_ST, tb_cycles, 1'b1, "st_wr_ign", -1);
      st0 = SysTick;
      repeat (16) cyc();
      check_eq("st_window", SysTick - st0, 32'd16);

      // TH read-back with random data
      for (int i = 0; i < 4; i++) begin
         rv = $urandom;
         bus_write(A_TH, rv);
         bus_read(A_TH, rv, 1'b1, "th_rb", -1);
      end

      // Reload and IRQ
      bus_write(A_TH,   32'hFFFF_FFFD);
      bus_write(A_TL,   32'hFFFF_FFFE);
      bus_write(A_TCON, 32'd3);
      bus_read(A_TL, 32'hFFFF_FFFE, 1'b1, "rl_c1", 0);
      bus_read(A_TL, 32'hFFFF_FFFF, 1'b1, "rl_c2", 0);
      bus_read(A_TL, 32'hFFFF_FFFD, 1'b1, "rl_c3", 1);
      bus_read(A_TL, 32'hFFFF_FFFE, 1'b1, "rl_c4", 1);
      bus_read(A_TL, 32'hFFFF_FFFF, 1'b1, "rl_c5", 1);
      bus_read(A_TL, 32'hFFFF_FFFD, 1'b1, "rl_c6", 1);
      bus_read(A_TL, 32'hFFFF_FFFE, 1'b1, "rl_c7", 1);

      // W1C collides with overflow set: set wins
      bus_write(A_TCON, 32'd7);
      bus_read(A_TCON, 32'd7, 1'b1, "w1c_coll", 1);
      // W1C on a quiet cycle clears status and stops the timer
      bus_write(A_TCON, 32'd4);
      bus_read(A_TCON, 32'd0, 1'b1, "w1c_clr", 0);
      bus_read(A_TL, 32'hFFFF_FFFF, 1'b1, "hold_a", 0);
      bus_read(A_TL, 32'hFFFF_FFFF, 1'b1, "hold_b", 0);

      // TL write in an overflow cycle: write wins, no IRQ
      bus_write(A_TH,   32'd0);
      bus_write(A_TCON, 32'd3);
      bus_write(A_TL,   32'd5);
      bus_read(A_TL, 32'd5, 1'b1, "tlwr_a", 0);
      bus_read(A_TL, 32'd6, 1'b1, "tlwr_b", 0);

      // TH write in an overflow cycle: reload uses old TH
      bus_write(A_TCON, 32'd0);
      bus_write(A_TH,   32'h10);
      bus_write(A_TL,   32'hFFFF_FFFF);
      bus_write(A_TCON, 32'd1);
      bus_write(A_TH,   32'h20);
      bus_read(A_TL, 32'h10, 1'b1, "thwr_tl", 0);
      bus_read(A_TH, 32'h20, 1'b1, "thwr_th", 0);

      // TH = all ones: overflow every tick, TL stuck at all ones
      bus_write(A_TCON, 32'd0);
      bus_write(A_TH,   32'hFFFF_FFFF);
      bus_write(A_TL,   32'hFFFF_FFFF);
      bus_write(A_TCON, 32'd3);
      bus_read(A_TL, 32'hFFFF_FFFF, 1'b1, "thmax_a", 0);
      bus_read(A_TL, 32'hFFFF_FFFF, 1'b1, "thmax_b", 1);
      bus_read(A_TL, 32'hFFFF_FFFF, 1'b1, "thmax_c", 1);

      // Reset mid-count clears everything; timer stays stopped
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      bus_read(A_TL,   32'd0, 1'b1, "mrst_tl",   0);
      bus_read(A_TCON, 32'd0, 1'b1, "mrst_tcon", 0);
      bus_read(A_TH,   32'd0, 1'b1, "mrst_th",   0);
      bus_read(A_TL,   32'd0, 1'b1, "mrst_tl2",  0);
      bus_read(A_ST, tb_cycles, 1'b1, "mrst_st", 0);

`ifdef TIMER_PRESCALE_EN
      // Prescale by 4, then a TL write restarts the prescaler
      bus_write(A_TCON, 32'd0);
      bus_write(A_TH,   32'd0);
      bus_write(A_TL,   32'd0);
      bus_write(A_TCON, 32'd1);
      for (int k = 1; k <= 9; k++) begin
         bus_read(A_TL, 32'((k - 1) / 4), 1'b1, "ps_cnt", 0);
      end
      bus_write(A_TL, 32'd10);
      for (int k = 1; k <= 5; k++) begin
         bus_read(A_TL, (k == 5) ? 32'd11 : 32'd10, 1'b1, "ps_rst", 0);
      end
`endif

      cyc();
      check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
